wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter StarveLimit, default 4, meaning: consecutive denied aux cycles before aux is forced to win (legal range 1..15).
REQ-002 Parameter ClearDataOnReset, default 0, meaning: zero the output data/rd registers on reset.
REQ-003 clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  reset; synchronous and active-high.
REQ-005 pipeline_flush  input  1  kill the pipe request presented this cycle.
REQ-006 p_valid_i / p_ready_o  input / output  1 / 1  pipe requester handshake (MEM/WB stage output).
REQ-007 p_rd_i, p_data_i, p_we_i  input  4, 32, 1  pipe destination register, result and RegWrite.
REQ-008 a_valid_i / a_ready_o  input / output  1 / 1  aux requester handshake (multi-cycle unit result).
REQ-009 a_rd_i, a_data_i  input  4, 32  aux destination register and result; aux always writes.
REQ-010 rf_we_o, rf_rd_o, rf_data_o  output  1, 4, 32  registered register-file write port.
REQ-011 grant_aux_o  output  1  registered; high when the current rf write came from aux.

Function
REQ-012 Transfers: pipe fires when p_valid_i & p_ready_o; aux fires when a_valid_i & a_ready_o; at most one fires per cycle.
REQ-013 FSM states PIPE_PRI and AUX_FORCE; PIPE_PRI: pipe wins contention; AUX_FORCE: aux wins contention.
REQ-014 No contention: a lone valid requester SHALL be granted (ready high) in either state.
REQ-015 Starvation counter increments each cycle a_valid_i is high and aux is not granted; clears on aux grant or a_valid_i low.
REQ-016 PIPE_PRI -> AUX_FORCE when the counter reaches StarveLimit; AUX_FORCE -> PIPE_PRI on the cycle aux fires.
REQ-017 pipeline_flush high: p_ready_o SHALL be 1, pipe request discarded (no write, no grant), aux arbitrated as if p_valid_i were 0.
REQ-018 Latency: fired request appears on rf_* exactly one cycle later; rf_we_o is a single-cycle pulse per transfer.
REQ-019 rf_we_o SHALL be 0 when the winning rd is 0 (x0) or when pipe wins with p_we_i=0; handshake still completes.
REQ-020 Cycle with no transfer: rf_we_o=0, rf_rd_o/rf_data_o hold previous values.
REQ-021 ready outputs are combinational from state, valids and flush; no combinational path from ready to valid.

Reset
REQ-022 During reset: state=PIPE_PRI, counter=0, rf_we_o=0, grant_aux_o=0, p_ready_o=a_ready_o=0.
REQ-023 rf_rd_o/rf_data_o zeroed only if ClearDataOnReset=1, else retain value.
REQ-024 Reset mid-contention discards both pending requests; first grant possible the cycle after reset deasserts.

Configuration
REQ-025 Macro WB_ARBITER_STATS_EN defined: adds output conflict_cnt_o [15:0], counting cycles both valid (flush low), saturating at 16'hFFFF, cleared by reset.
REQ-026 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-027 Package wb_arb_pkg holds state enum (PIPE_PRI, AUX_FORCE), RegAddrWidth=4, DataWidth=32.
REQ-028 Sub-module wb_starve_cnt holds the starvation counter and limit compare; arbitration FSM and output registers stay in wb_arbiter.

Verification
REQ-029 Pipe only, rd=5, data=32'hDEADBEEF, we=1 -> next cycle rf_we_o=1, rf_rd_o=5, rf_data_o=32'hDEADBEEF, grant_aux_o=0.
REQ-030 Both valid continuously, StarveLimit=4 -> pipe wins 4 cycles, aux wins 5th cycle, pipe wins 6th.
REQ-031 Both valid, pipeline_flush=1 -> aux granted same cycle, pipe not written, a_ready_o=1, p_ready_o=1.
REQ-032 Aux rd=0, data=32'h1234 -> a_ready_o=1, next cycle rf_we_o=0; pipe p_we_i=0 rd=7 -> rf_we_o=0.
REQ-033 Reset asserted while AUX_FORCE with counter at 4 -> after reset state PIPE_PRI, counter 0, contention grants pipe first.
REQ-034 STATS_EN build, 10 contention cycles -> conflict_cnt_o=10; forced to 16'hFFFF -> stays 16'hFFFF.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and widths for the writeback arbiter
// Optional build macro used by wb_arbiter: WB_ARBITER_STATS_EN
package wb_arb_pkg;
   localparam int RegAddrWidth   = 4;
   localparam int DataWidth      = 32;
   localparam int StarveCntWidth = 4;

   typedef enum logic {
      PIPE_PRI  = 1'b0,
      AUX_FORCE = 1'b1
   } arb_state_e;
endpackage

// File: rtl/wb_starve_cnt.sv
// rtl/wb_starve_cnt.sv - aux starvation counter with limit compare
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset
//   a_valid_i    aux requester valid
//   a_fire_i     aux transfer completes this cycle
//   limit_hit_o  counter reaches StarveLimit at the coming clock edge
module wb_starve_cnt
   import wb_arb_pkg::*;
#(
   parameter int StarveLimit = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic a_valid_i,
   input  logic a_fire_i,
   output logic limit_hit_o
);

   logic [StarveCntWidth-1:0] cnt_q;
   logic [StarveCntWidth-1:0] cnt_nxt;

   // Counts consecutive cycles aux waits; any aux grant or idle aux restarts it.
   always_comb begin
      cnt_nxt = '0;
      if (a_valid_i && !a_fire_i) begin
         cnt_nxt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
   end

   // Looks at the value being loaded so the FSM flips on the same edge the
   // counter reaches the limit; aux then wins the very next contention cycle.
   assign limit_hit_o = (cnt_nxt >= StarveCntWidth'(StarveLimit));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_nxt;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-requester register-file writeback arbiter
// Build macro: WB_ARBITER_STATS_EN adds conflict_cnt_o.
// Ports:
//   clk_i, reset_i                   clock, synchronous active-high reset
//   pipeline_flush                   discard the pipe request this cycle
//   p_valid_i/p_ready_o              pipe handshake; p_rd_i, p_data_i, p_we_i payload
//   a_valid_i/a_ready_o              aux handshake; a_rd_i, a_data_i payload
//   rf_we_o, rf_rd_o, rf_data_o      registered register-file write port
//   conflict_cnt_o                   saturating contention-cycle count (stats build)
//   grant_aux_o                      registered, current rf transfer came from aux
module wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int StarveLimit      = 4,
   parameter bit ClearDataOnReset = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    pipeline_flush,
   input  logic                    p_valid_i,
   output logic                    p_ready_o,
   input  logic [RegAddrWidth-1:0] p_rd_i,
   input  logic [DataWidth-1:0]    p_data_i,
   input  logic                    p_we_i,
   input  logic                    a_valid_i,
   output logic                    a_ready_o,
   input  logic [RegAddrWidth-1:0] a_rd_i,
   input  logic [DataWidth-1:0]    a_data_i,
   output logic                    rf_we_o,
   output logic [RegAddrWidth-1:0] rf_rd_o,
   output logic [DataWidth-1:0]    rf_data_o,
`ifdef WB_ARBITER_STATS_EN
   output logic [15:0]             conflict_cnt_o,
`endif
   output logic                    grant_aux_o
);

   arb_state_e state_q;
   arb_state_e state_nxt;
   logic       p_eff;
   logic       p_fire;
   logic       a_fire;
   logic       limit_hit;

   // A flushed pipe request is invisible to arbitration.
   assign p_eff = p_valid_i & ~pipeline_flush;

   // Flush forces p_ready_o high so the killed request still drains.
   always_comb begin
      p_ready_o = 1'b0;
      a_ready_o = 1'b0;
      if (!reset_i) begin
         p_ready_o = pipeline_flush | (state_q == PIPE_PRI) | ~a_valid_i;
         a_ready_o = ~p_eff | (state_q == AUX_FORCE);
      end
   end

   assign p_fire = p_eff & p_ready_o;
   assign a_fire = a_valid_i & a_ready_o;

   wb_starve_cnt #(
      .StarveLimit(StarveLimit)
   ) u_starve_cnt (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .a_valid_i  (a_valid_i),
      .a_fire_i   (a_fire),
      .limit_hit_o(limit_hit)
   );

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         PIPE_PRI:  if (limit_hit) state_nxt = AUX_FORCE;
         AUX_FORCE: if (a_fire)    state_nxt = PIPE_PRI;
         default:   state_nxt = PIPE_PRI;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= PIPE_PRI;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Writes to x0 are suppressed but the handshake still completes.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rf_we_o     <= 1'b0;
         grant_aux_o <= 1'b0;
         if (ClearDataOnReset) begin
            rf_rd_o   <= '0;
            rf_data_o <= '0;
         end
      end else if (p_fire) begin
         rf_we_o     <= p_we_i & (p_rd_i != '0);
         rf_rd_o     <= p_rd_i;
         rf_data_o   <= p_data_i;
         grant_aux_o <= 1'b0;
      end else if (a_fire) begin
         rf_we_o     <= (a_rd_i != '0);
         rf_rd_o     <= a_rd_i;
         rf_data_o   <= a_data_i;
         grant_aux_o <= 1'b1;
      end else begin
         rf_we_o     <= 1'b0;
         grant_aux_o <= 1'b0;
      end
   end

`ifdef WB_ARBITER_STATS_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         conflict_cnt_o <= '0;
      end else if (p_eff && a_valid_i && conflict_cnt_o != 16'hFFFF) begin
         conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter
module tb_wb_arbiter;

   localparam int Limit = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        p_valid = 1'b0;
   logic        p_ready;
   logic [3:0]  p_rd = '0;
   logic [31:0] p_data = '0;
   logic        p_we = 1'b0;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [3:0]  a_rd = '0;
   logic [31:0] a_data = '0;
   logic        rf_we;
   logic [3:0]  rf_rd;
   logic [31:0] rf_data;
   logic        grant_aux;
`ifdef WB_ARBITER_STATS_EN
   logic [15:0] conflict_cnt;
`endif

   always #5 clk = ~clk;

   wb_arbiter #(
      .StarveLimit(Limit),
      .ClearDataOnReset(1'b0)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .pipeline_flush(flush),
      .p_valid_i     (p_valid),
      .p_ready_o     (p_ready),
      .p_rd_i        (p_rd),
      .p_data_i      (p_data),
      .p_we_i        (p_we),
      .a_valid_i     (a_valid),
      .a_ready_o     (a_ready),
      .a_rd_i        (a_rd),
      .a_data_i      (a_data),
      .rf_we_o       (rf_we),
      .rf_rd_o       (rf_rd),
      .rf_data_o     (rf_data),
`ifdef WB_ARBITER_STATS_EN
      .conflict_cnt_o(conflict_cnt),
`endif
      .grant_aux_o   (grant_aux)
   );

   typedef struct {
      bit          we;
      bit          grant;
      bit          known;
      logic [3:0]  rd;
      logic [31:0] data;
      int          conf;
   } exp_t;

   exp_t        sb_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   // Reference model state
   int          starve = 0;
   bit          forced = 1'b0;
   bit          known = 1'b0;
   logic [3:0]  last_rd = '0;
   logic [31:0] last_data = '0;
   int          conf = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst, input bit fl, input bit pv, input logic [3:0] prd,
                       input logic [31:0] pdat, input bit pwe, input bit av,
                       input logic [3:0] ard, input logic [31:0] adat);
      bit   pw;
      bit   aw;
      bit   pe;
      exp_t e;
      @(negedge clk);
      reset = rst; flush = fl;
      p_valid = pv; p_rd = prd; p_data = pdat; p_we = pwe;
      a_valid = av; a_rd = ard; a_data = adat;
      #1;
      pw = 1'b0;
      aw = 1'b0;
      pe = pv && !fl;
      if (!rst) begin
         if (pe && av) begin
            if (forced) aw = 1'b1;
            else        pw = 1'b1;
         end else if (pe) begin
            pw = 1'b1;
         end else if (av) begin
            aw = 1'b1;
         end
      end
      if (rst) begin
         chk("p_ready_in_reset", {31'd0, p_ready}, 32'd0);
         chk("a_ready_in_reset", {31'd0, a_ready}, 32'd0);
      end else begin
         if (pv || fl) chk("p_ready", {31'd0, p_ready}, {31'd0, (fl || pw)});
         if (av)       chk("a_ready", {31'd0, a_ready}, {31'd0, aw});
      end

      e.we = 1'b0;
      e.grant = 1'b0;
      if (rst) begin
         starve = 0;
         forced = 1'b0;
         conf = 0;
      end else begin
         if (pv && av && !fl && conf < 65535) conf++;
         if (pw) begin
            e.we = pwe && (prd != 4'd0);
            last_rd = prd;
            last_data = pdat;
            known = 1'b1;
         end else if (aw) begin
            e.we = (ard != 4'd0);
            e.grant = 1'b1;
            last_rd = ard;
            last_data = adat;
            known = 1'b1;
         end
         if (aw) begin
            starve = 0;
            forced = 1'b0;
         end else if (av) begin
            starve++;
            if (starve >= Limit) forced = 1'b1;
         end else begin
            starve = 0;
         end
      end
      e.known = known;
      e.rd = last_rd;
      e.data = last_data;
      e.conf = conf;
      sb_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
            chk("grant_aux", {31'd0, grant_aux}, {31'd0, e.grant});
            if (e.known) begin
               chk("rf_rd", {28'd0, rf_rd}, {28'd0, e.rd});
               chk("rf_data", rf_data, e.data);
            end
`ifdef WB_ARBITER_STATS_EN
            chk("conflict_cnt", {16'd0, conflict_cnt}, e.conf);
`endif
         end
      end
   end

   initial begin : stim
      step(1, 0, 1, 4'd3, 32'h1, 1, 1, 4'd4, 32'h2);
      step(1, 0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0);
      // lone pipe write
      step(0, 0, 1, 4'd5, 32'hDEADBEEF, 1, 0, 4'd0, 32'h0);
      // continuous contention: four pipe wins, then aux, then pipe
      for (int i = 0; i < 6; i++)
         step(0, 0, 1, 4'(i + 1), 32'hA000_0000 + i, 1, 1, 4'd9, 32'hB000_0000 + i);
      // flush with both valid: aux goes straight through
      step(0, 1, 1, 4'd6, 32'hCAFE, 1, 1, 4'd8, 32'hF00D);
      // writes suppressed: aux to x0, pipe with we low
      step(0, 0, 0, 4'd0, 32'h0, 0, 1, 4'd0, 32'h1234);
      step(0, 0, 1, 4'd7, 32'h5555, 0, 0, 4'd0, 32'h0);
      // drive into AUX_FORCE, reset, then contention must favour pipe
      for (int i = 0; i < 4; i++)
         step(0, 0, 1, 4'd2, 32'hC0 + i, 1, 1, 4'd3, 32'hD0 + i);
      step(1, 0, 1, 4'd2, 32'hE0, 1, 1, 4'd3, 32'hE1);
      step(0, 0, 1, 4'd10, 32'hE2, 1, 1, 4'd11, 32'hE3);
      step(0, 0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0);
      // randomized traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              4'($urandom_range(0, 15)), $urandom);
      step(0, 0, 0, 4'd0, 32'h0, 0, 0, 4'd0, 32'h0);
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
